alu_seq_mpy_div: RTL and testbench
==================================

Name: alu_seq_mpy_div

Overview:
- Parametrised, multicycle successor to the combinational 32-bit ALU datapath. It executes shifts, signed/unsigned multiply and signed/unsigned divide on WIDTH-bit operands.
- Multiply uses an iterative shift-add engine; divide uses a restoring engine. Results are registered into HI/LO output registers.
- Sits beside the integer ALU in the execute stage. The control unit issues an operation with start and stalls until done.

Parameters:
- WIDTH, 32, operand and result width; must be an even integer >= 8.
- SHW, $clog2(WIDTH), shift-amount width. Derived localparam; not overridable.

Ports:
- clk, input, 1, rising-edge clock.
- reset, input, 1, asynchronous, active-low reset.
- start, input, 1, single-cycle request; sampled only when busy=0.
- FS, input, 6, function select.
- S, input, WIDTH, operand A (dividend / multiplicand).
- T, input, WIDTH, operand B (divisor / multiplier / shift source).
- shamt, input, SHW, shift amount.
- busy, output, 1, high from the edge after an accepted start until done.
- done, output, 1, one-cycle pulse when results are valid.
- Y_hi, output, WIDTH, high product / remainder; 0 for shifts.
- Y_lo, output, WIDTH, low product / quotient / shift result.
- C, output, 1, carry flag.
- V, output, 1, overflow / exception flag.
- N, output, 1, negative flag.
- Z, output, 1, zero flag.

Behaviour:
- Reset: all outputs 0, FSM to IDLE. Reset asserted mid-operation aborts the operation immediately; no done is produced.
- Function codes:
  - 0x0C SLL, 0x0D SRL, 0x0E SRA.
  - 0x1E MUL (signed), 0x1C MULU.
  - 0x1F DIV (signed), 0x1D DIVU.
  - Any other code is ILLEGAL.
- Accept: start=1 while busy=0 latches FS, S, T and shamt on that edge. start while busy=1 is ignored and never queued.
- FSM states: IDLE, CALC, FIX, DONE.
  - IDLE -> DONE for shifts, ILLEGAL and divide-by-zero.
  - IDLE -> CALC for MUL/DIV with a nonzero divisor.
  - CALC runs exactly WIDTH iterations, one per edge (counter 0..WIDTH-1), then -> FIX.
  - FIX applies sign correction and loads Y_hi/Y_lo/flags, then -> DONE.
  - DONE pulses done for one cycle and deasserts busy, then -> IDLE.
- Latency, counted from the accept edge to the first cycle in which done=1:
  - Shift, ILLEGAL, divide-by-zero: 1 edge.
  - MUL/DIV: WIDTH+2 edges.
- A new start is accepted in the same cycle done=1, giving back-to-back throughput.
- Outputs hold their last values until the next operation loads new ones. Flags update only together with Y.
- Multiply:
  - Signed operations take the magnitudes of S and T, iterate, then negate the 2*WIDTH-bit product in FIX if the operand signs differ.
  - {Y_hi, Y_lo} = full product.
  - C=0, V=0, N=Y_hi[MSB], Z=({Y_hi,Y_lo}==0).
- Divide:
  - Quotient truncates toward zero; the remainder takes the sign of the dividend. Y_lo=quotient, Y_hi=remainder.
  - DIV with S=MIN_INT and T=-1: Y_lo=MIN_INT, Y_hi=0, V=1, normal latency.
  - T=0 for either divide: Y_lo=all ones, Y_hi=S, V=1, 1-edge latency.
  - Otherwise V=0. C=0 always. N=Y_lo[MSB], Z=(Y_lo==0).
- Shift:
  - Y_lo=T shifted by shamt; SRA sign-fills. Y_hi=0.
  - C=last bit shifted out; C=0 when shamt=0.
  - V=0, N=Y_lo[MSB], Z=(Y_lo==0).
- ILLEGAL: Y_hi=Y_lo=0, V=1, Z=1, C=N=0.
- The engine uses its latched operands only; changing S/T/FS while busy has no effect.

Test Plan:
- WIDTH=32, MUL S=0xFFFFFFFD (-3), T=7 -> done on edge 34 after accept; Y_hi=0xFFFFFFFF, Y_lo=0xFFFFFFEB, N=1, V=0.
- DIVU S=100, T=7 -> Y_lo=14, Y_hi=2. Then DIV S=-7, T=2 -> Y_lo=0xFFFFFFFD, Y_hi=0xFFFFFFFF, N=1. Both issued back-to-back, with the second start asserted in the cycle done=1.
- DIV S=5, T=0 -> done after 1 edge, Y_lo=0xFFFFFFFF, Y_hi=5, V=1. DIV S=0x80000000, T=0xFFFFFFFF -> Y_lo=0x80000000, Y_hi=0, V=1, done on edge 34.
- SRA T=0x80000000, shamt=4 -> Y_lo=0xF8000000, C=0, N=1. SLL T=0x80000001, shamt=1 -> Y_lo=0x00000002, C=1. FS=0x3F -> V=1, Z=1.
- MULU started, then start pulsed at cycle 5 with FS=SLL -> second request ignored; only one done, carrying the MULU result.
- reset driven low at cycle 10 of a DIV -> busy=0, done=0, Y_hi=Y_lo=0 immediately. After release, a new MUL 6*7 gives Y_lo=42 and Y_hi=0.

Source files
------------

// File: rtl/alu_seq_mpy_div.sv
// Multicycle shift / multiply / divide unit for the execute stage.
// Shift-add multiplier and restoring divider share one HI/LO working register pair.
module alu_seq_mpy_div #(
  parameter int unsigned WIDTH = 32,
  localparam int unsigned SHW = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [5:0]       FS,
  input  logic [WIDTH-1:0] S,
  input  logic [WIDTH-1:0] T,
  input  logic [SHW-1:0]   shamt,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Y_hi,
  output logic [WIDTH-1:0] Y_lo,
  output logic             C,
  output logic             V,
  output logic             N,
  output logic             Z
);

  localparam logic [5:0] FnSll  = 6'h0C;
  localparam logic [5:0] FnSrl  = 6'h0D;
  localparam logic [5:0] FnSra  = 6'h0E;
  localparam logic [5:0] FnMul  = 6'h1E;
  localparam logic [5:0] FnMulu = 6'h1C;
  localparam logic [5:0] FnDiv  = 6'h1F;
  localparam logic [5:0] FnDivu = 6'h1D;
  localparam logic [SHW-1:0] CntLast = SHW'(WIDTH - 1);

  typedef enum logic [1:0] {StIdle, StCalc, StFix, StDone} state_e;

  state_e             state_q, state_d;
  logic [SHW-1:0]     cnt_q, cnt_d;
  logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d, opb_q, opb_d;
  logic               is_div_q, is_div_d, neg_lo_q, neg_lo_d, neg_hi_q, neg_hi_d, ovf_q, ovf_d;
  logic [WIDTH-1:0]   yhi_q, yhi_d, ylo_q, ylo_d;
  logic               c_q, c_d, v_q, v_d, n_q, n_d, z_q, z_d;

  // Operation decode on the live inputs; only used on the accept edge.
  logic op_mul, op_div, op_signed, op_shift, t_zero, s_neg, t_neg, min_by_neg1;
  logic [WIDTH-1:0] s_mag, t_mag;

  assign op_mul      = (FS == FnMul) || (FS == FnMulu);
  assign op_div      = (FS == FnDiv) || (FS == FnDivu);
  assign op_signed   = (FS == FnMul) || (FS == FnDiv);
  assign op_shift    = (FS == FnSll) || (FS == FnSrl) || (FS == FnSra);
  assign t_zero      = (T == '0);
  assign s_neg       = op_signed & S[WIDTH-1];
  assign t_neg       = op_signed & T[WIDTH-1];
  assign s_mag       = s_neg ? -S : S;
  assign t_mag       = t_neg ? -T : T;
  assign min_by_neg1 = (FS == FnDiv) && (S == {1'b1, {(WIDTH-1){1'b0}}}) && (&T);

  // Shifts use one guard bit to capture the last bit shifted out.
  logic [WIDTH:0]        sll_ext, srl_ext, sra_ext;
  logic signed [WIDTH:0] t_ext_s;
  logic [WIDTH-1:0]      sh_y;
  logic                  sh_c;

  assign sll_ext = {1'b0, T} << shamt;
  assign srl_ext = {T, 1'b0} >> shamt;
  assign t_ext_s = {T, 1'b0};
  assign sra_ext = t_ext_s >>> shamt;

  always_comb begin
    sh_y = srl_ext[WIDTH:1];
    sh_c = srl_ext[0];
    if (FS == FnSll) begin
      sh_y = sll_ext[WIDTH-1:0];
      sh_c = sll_ext[WIDTH];
    end else if (FS == FnSra) begin
      sh_y = sra_ext[WIDTH:1];
      sh_c = sra_ext[0];
    end
  end

  // Iteration datapaths and final sign correction.
  logic [WIDTH:0]     mul_sum, div_rem_sh, div_diff;
  logic [2*WIDTH-1:0] prod_raw, prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix;

  assign mul_sum    = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opb_q} : {(WIDTH+1){1'b0}});
  assign div_rem_sh = {hi_q, lo_q[WIDTH-1]};
  assign div_diff   = div_rem_sh - {1'b0, opb_q};
  assign prod_raw   = {hi_q, lo_q};
  assign prod_fix   = neg_lo_q ? -prod_raw : prod_raw;
  assign quo_fix    = neg_lo_q ? -lo_q : lo_q;
  assign rem_fix    = neg_hi_q ? -hi_q : hi_q;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    opb_d    = opb_q;
    is_div_d = is_div_q;
    neg_lo_d = neg_lo_q;
    neg_hi_d = neg_hi_q;
    ovf_d    = ovf_q;
    yhi_d    = yhi_q;
    ylo_d    = ylo_q;
    c_d      = c_q;
    v_d      = v_q;
    n_d      = n_q;
    z_d      = z_q;
    unique case (state_q)
      StIdle, StDone: begin
        state_d = StIdle;
        if (start) begin
          cnt_d = '0;
          if (op_mul) begin
            hi_d     = '0;
            lo_d     = t_mag;
            opb_d    = s_mag;
            is_div_d = 1'b0;
            neg_lo_d = s_neg ^ t_neg;
            neg_hi_d = 1'b0;
            ovf_d    = 1'b0;
            state_d  = StCalc;
          end else if (op_div && !t_zero) begin
            hi_d     = '0;
            lo_d     = s_mag;
            opb_d    = t_mag;
            is_div_d = 1'b1;
            neg_lo_d = s_neg ^ t_neg;
            neg_hi_d = s_neg;
            ovf_d    = min_by_neg1;
            state_d  = StCalc;
          end else begin
            // Single-edge results: shifts, divide-by-zero, illegal codes.
            state_d = StDone;
            yhi_d   = '0;
            c_d     = 1'b0;
            v_d     = 1'b0;
            if (op_div) begin
              ylo_d = '1;
              yhi_d = S;
              v_d   = 1'b1;
            end else if (op_shift) begin
              ylo_d = sh_y;
              c_d   = sh_c;
            end else begin
              ylo_d = '0;
              v_d   = 1'b1;
            end
            n_d = ylo_d[WIDTH-1];
            z_d = (ylo_d == '0);
          end
        end
      end
      StCalc: begin
        if (is_div_q) begin
          if (!div_diff[WIDTH]) begin
            hi_d = div_diff[WIDTH-1:0];
            lo_d = {lo_q[WIDTH-2:0], 1'b1};
          end else begin
            hi_d = div_rem_sh[WIDTH-1:0];
            lo_d = {lo_q[WIDTH-2:0], 1'b0};
          end
        end else begin
          hi_d = mul_sum[WIDTH:1];
          lo_d = {mul_sum[0], lo_q[WIDTH-1:1]};
        end
        cnt_d = cnt_q + SHW'(1);
        if (cnt_q == CntLast) state_d = StFix;
      end
      StFix: begin
        c_d = 1'b0;
        if (is_div_q) begin
          ylo_d = quo_fix;
          yhi_d = rem_fix;
          v_d   = ovf_q;
          n_d   = quo_fix[WIDTH-1];
          z_d   = (quo_fix == '0);
        end else begin
          {yhi_d, ylo_d} = prod_fix;
          v_d   = 1'b0;
          n_d   = prod_fix[2*WIDTH-1];
          z_d   = (prod_fix == '0);
        end
        state_d = StDone;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      opb_q    <= '0;
      is_div_q <= 1'b0;
      neg_lo_q <= 1'b0;
      neg_hi_q <= 1'b0;
      ovf_q    <= 1'b0;
      yhi_q    <= '0;
      ylo_q    <= '0;
      c_q      <= 1'b0;
      v_q      <= 1'b0;
      n_q      <= 1'b0;
      z_q      <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      opb_q    <= opb_d;
      is_div_q <= is_div_d;
      neg_lo_q <= neg_lo_d;
      neg_hi_q <= neg_hi_d;
      ovf_q    <= ovf_d;
      yhi_q    <= yhi_d;
      ylo_q    <= ylo_d;
      c_q      <= c_d;
      v_q      <= v_d;
      n_q      <= n_d;
      z_q      <= z_d;
    end
  end

  assign busy = (state_q == StCalc) || (state_q == StFix);
  assign done = (state_q == StDone);
  assign Y_hi = yhi_q;
  assign Y_lo = ylo_q;
  assign C    = c_q;
  assign V    = v_q;
  assign N    = n_q;
  assign Z    = z_q;

endmodule

// File: tb/tb_alu_seq_mpy_div.sv
// Bench for alu_seq_mpy_div (WIDTH=32): directed cases plus random operations
// checked against a 64-bit arithmetic reference model.
module tb_alu_seq_mpy_div;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [5:0]  FS;
  logic [31:0] S, T;
  logic [4:0]  shamt;
  logic        busy, done, C, V, N, Z;
  logic [31:0] Y_hi, Y_lo;

  alu_seq_mpy_div #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .start(start), .FS(FS), .S(S), .T(T), .shamt(shamt),
    .busy(busy), .done(done), .Y_hi(Y_hi), .Y_lo(Y_lo), .C(C), .V(V), .N(N), .Z(Z)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] last_hi, last_lo;
  logic [3:0]  last_flags;
  logic [5:0]  codes [7] = '{6'h0C, 6'h0D, 6'h0E, 6'h1E, 6'h1C, 6'h1F, 6'h1D};

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: plain 64-bit arithmetic, SV division truncates toward zero.
  function automatic void model(input logic [5:0] fs, input logic [31:0] s, input logic [31:0] t,
                                input logic [4:0] sh, output logic [31:0] hi,
                                output logic [31:0] lo, output logic [3:0] flags,
                                output int lat);
    longint a, b, q, r;
    longint unsigned p;
    logic c, v, n, z;
    c = 1'b0; v = 1'b0; hi = '0; lo = '0; lat = 1;
    case (fs)
      6'h0C: begin lo = t << sh; c = (sh != 0) ? t[32 - int'(sh)] : 1'b0; end
      6'h0D: begin lo = t >> sh; c = (sh != 0) ? t[int'(sh) - 1] : 1'b0; end
      6'h0E: begin lo = $signed(t) >>> sh; c = (sh != 0) ? t[int'(sh) - 1] : 1'b0; end
      6'h1E, 6'h1C: begin
        if (fs == 6'h1E) p = longint'($signed(s)) * longint'($signed(t));
        else             p = {32'b0, s} * {32'b0, t};
        {hi, lo} = p;
        lat = 34;
      end
      6'h1F, 6'h1D: begin
        if (t == 0) begin
          lo = '1; hi = s; v = 1'b1;
        end else begin
          if (fs == 6'h1F) begin a = longint'($signed(s)); b = longint'($signed(t)); end
          else             begin a = longint'({32'b0, s}); b = longint'({32'b0, t}); end
          q = a / b;
          r = a % b;
          lo = q[31:0];
          hi = r[31:0];
          v = (fs == 6'h1F) && (s == 32'h8000_0000) && (t == 32'hFFFF_FFFF);
          lat = 34;
        end
      end
      default: begin
        v = 1'b1;
      end
    endcase
    if (fs == 6'h1E || fs == 6'h1C) begin
      n = hi[31]; z = ({hi, lo} == 64'd0);
    end else begin
      n = lo[31]; z = (lo == 32'd0);
    end
    flags = {c, v, n, z};
  endfunction

  // Called at a negedge while the DUT can accept; returns at the negedge where done=1.
  task automatic run_op(input logic [5:0] fs, input logic [31:0] s, input logic [31:0] t,
                        input logic [4:0] sh, output int lat, output logic busy_seen);
    FS = fs; S = s; T = t; shamt = sh; start = 1'b1;
    @(posedge clk);
    lat = 1;
    @(negedge clk);
    start = 1'b0;
    busy_seen = busy;
    FS = 6'($urandom); S = $urandom; T = $urandom; shamt = 5'($urandom);
    while (!done && lat < 100) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
  endtask

  task automatic check_op(input string tag, input logic [5:0] fs, input logic [31:0] s,
                          input logic [31:0] t, input logic [4:0] sh);
    logic [31:0] ehi, elo;
    logic [3:0]  eflags;
    int          elat, lat;
    logic        bs;
    model(fs, s, t, sh, ehi, elo, eflags, elat);
    run_op(fs, s, t, sh, lat, bs);
    chk({tag, "/latency"}, 64'(lat), 64'(elat));
    chk({tag, "/done"}, 64'(done), 64'd1);
    chk({tag, "/busy"}, 64'(bs), 64'(elat > 1));
    chk({tag, "/Y_hi"}, 64'(Y_hi), 64'(ehi));
    chk({tag, "/Y_lo"}, 64'(Y_lo), 64'(elo));
    chk({tag, "/CVNZ"}, 64'({C, V, N, Z}), 64'(eflags));
    last_hi = ehi; last_lo = elo; last_flags = eflags;
  endtask

  task automatic idle_check(input string tag);
    @(negedge clk);
    chk({tag, "/done_pulse"}, 64'(done), 64'd0);
    chk({tag, "/hold"}, {Y_hi, Y_lo}, {last_hi, last_lo});
    chk({tag, "/hold_flags"}, 64'({C, V, N, Z}), 64'(last_flags));
  endtask

  function automatic logic [31:0] rnd_operand();
    case ($urandom_range(0, 7))
      0:       return 32'd0;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return $urandom_range(0, 15);
      default: return $urandom;
    endcase
  endfunction

  logic [31:0] ig_a, ig_b, ig_hi, ig_lo, got_hi, got_lo;
  logic [3:0]  ig_flags;
  int          ig_lat, edges, n_done, done_edge;

  initial begin
    reset = 1'b0; start = 1'b0; FS = '0; S = '0; T = '0; shamt = '0;
    repeat (2) @(negedge clk);
    chk("reset/busy_done", 64'({busy, done}), 64'd0);
    chk("reset/Y", {Y_hi, Y_lo}, 64'd0);
    chk("reset/CVNZ", 64'({C, V, N, Z}), 64'd0);
    reset = 1'b1;
    @(negedge clk);

    check_op("mul_neg3x7", 6'h1E, 32'hFFFF_FFFD, 32'd7, 5'd0);
    idle_check("mul_neg3x7");
    check_op("divu_100_7", 6'h1D, 32'd100, 32'd7, 5'd0);
    check_op("div_b2b_m7_2", 6'h1F, 32'hFFFF_FFF9, 32'd2, 5'd0);
    idle_check("div_b2b_m7_2");
    check_op("div_by0", 6'h1F, 32'd5, 32'd0, 5'd0);
    check_op("div_min_m1", 6'h1F, 32'h8000_0000, 32'hFFFF_FFFF, 5'd0);
    check_op("sra", 6'h0E, 32'd0, 32'h8000_0000, 5'd4);
    check_op("sll", 6'h0C, 32'd0, 32'h8000_0001, 5'd1);
    check_op("illegal", 6'h3F, 32'h1234_5678, 32'h9ABC_DEF0, 5'd7);
    idle_check("illegal");

    // A start pulsed while busy must be dropped, not queued.
    ig_a = $urandom | 32'd1;
    ig_b = $urandom | 32'd1;
    model(6'h1C, ig_a, ig_b, 5'd0, ig_hi, ig_lo, ig_flags, ig_lat);
    FS = 6'h1C; S = ig_a; T = ig_b; start = 1'b1;
    @(posedge clk);
    edges = 1; n_done = 0; done_edge = 0; got_hi = '0; got_lo = '0;
    for (int k = 0; k < 45; k++) begin
      @(negedge clk);
      if (done) begin
        n_done++;
        if (n_done == 1) begin done_edge = edges; got_hi = Y_hi; got_lo = Y_lo; end
      end
      if (edges == 5) begin start = 1'b1; FS = 6'h0C; T = 32'd1; shamt = 5'd3; end
      else start = 1'b0;
      @(posedge clk);
      edges++;
    end
    @(negedge clk);
    start = 1'b0;
    chk("ignore/done_count", 64'(n_done), 64'd1);
    chk("ignore/done_edge", 64'(done_edge), 64'(ig_lat));
    chk("ignore/Y", {got_hi, got_lo}, {ig_hi, ig_lo});

    // Reset in the middle of a divide aborts immediately.
    FS = 6'h1F; S = $urandom; T = 32'd3; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    chk("rst_mid/busy_before", 64'(busy), 64'd1);
    reset = 1'b0;
    #1;
    chk("rst_mid/busy_done", 64'({busy, done}), 64'd0);
    chk("rst_mid/Y", {Y_hi, Y_lo}, 64'd0);
    chk("rst_mid/CVNZ", 64'({C, V, N, Z}), 64'd0);
    @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_mid/no_done", 64'({busy, done}), 64'd0);
    check_op("mul_6x7", 6'h1E, 32'd6, 32'd7, 5'd0);

    for (int i = 0; i < 40; i++) begin
      logic [5:0] fs;
      int k;
      k = $urandom_range(0, 7);
      fs = (k == 7) ? 6'($urandom) : codes[k];
      check_op($sformatf("rand%0d_fs%02h", i, fs), fs, rnd_operand(), rnd_operand(),
               5'($urandom));
      if ($urandom_range(0, 2) == 0) idle_check($sformatf("rand%0d", i));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
